// File: rtl/riscv_ctrl_pipe_pkg.sv
// Shared RISC-V control definitions: opcodes, funct3, operand-source codes,
// 5-bit ALU codes and the packed control-bundle layout used by every stage.
package riscv_ctrl_pipe_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDV  = 7'b0000001;

    localparam logic [2:0] SRC_IMM_NONE = 3'd0;
    localparam logic [2:0] SRC_IMM_I    = 3'd1;
    localparam logic [2:0] SRC_IMM_S    = 3'd2;
    localparam logic [2:0] SRC_IMM_B    = 3'd3;
    localparam logic [2:0] SRC_IMM_U    = 3'd4;
    localparam logic [2:0] SRC_IMM_J    = 3'd5;
    localparam logic [1:0] SRC_RD_ALU   = 2'd0;
    localparam logic [1:0] SRC_RD_MEM   = 2'd1;
    localparam logic [1:0] SRC_RD_PC4   = 2'd2;
    localparam logic       SRC_A_PC     = 1'b1;
    localparam logic       SRC_B_IMM    = 1'b1;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam int OFF_FUNCT3    = 0;
    localparam int OFF_RS2       = 3;
    localparam int OFF_RS1       = 8;
    localparam int OFF_RD        = 13;
    localparam int OFF_IS_LOAD   = 18;
    localparam int OFF_ALU_CTRL  = 19;
    localparam int OFF_BYTE_SEL  = 24;
    localparam int OFF_MEM_WR    = 28;
    localparam int OFF_REG_WR    = 29;
    localparam int OFF_SRC_ALU_B = 30;
    localparam int OFF_SRC_ALU_A = 31;
    localparam int OFF_SRC_RD    = 32;
    localparam int OFF_SRC_IMM   = 34;
    localparam int CTRL_BUNDLE_W = 37;

    // First member is the MSB, so this matches the OFF_* offsets above.
    typedef struct packed {
        logic [2:0] src_imm;
        logic [1:0] src_rd;
        logic       src_alu_a;
        logic       src_alu_b;
        logic       reg_wr_en;
        logic       mem_wr_en;
        logic [3:0] mem_byte_sel;
        logic [4:0] alu_ctrl;
        logic       is_load;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
    } ctrl_bundle_t;

    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_from_f3 = ALU_SLL;
            F3_SLT:  alu_from_f3 = ALU_SLT;
            F3_SLTU: alu_from_f3 = ALU_SLTU;
            F3_XOR:  alu_from_f3 = ALU_XOR;
            F3_SR:   alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic mem_valid, input ctrl_bundle_t mem_b,
                                           input logic wb_valid, input ctrl_bundle_t wb_b);
        if (mem_valid && mem_b.reg_wr_en && mem_b.rd != 5'd0 && mem_b.rd == rs)
            fwd_sel = 2'b01;
        else if (wb_valid && wb_b.reg_wr_en && wb_b.rd != 5'd0 && wb_b.rd == rs)
            fwd_sel = 2'b10;
        else
            fwd_sel = 2'b00;
    endfunction

endpackage

// File: rtl/riscv_ctrl_pipe_dec.sv
// Combinational RV32I decoder (instr -> control bundle, illegal flag).
// M-extension decode is enabled by RISCV_CTRL_MULDIV_EN.
module riscv_ctrl_dec
    import riscv_ctrl_pipe_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle,
    output logic         illegal
);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       use_rs1;
    logic       use_rs2;
    logic       wr_rd;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        bundle              = '0;
        bundle.funct3       = f3;
        bundle.mem_byte_sel = 4'b1111;
        illegal             = 1'b0;
        use_rs1             = 1'b0;
        use_rs2             = 1'b0;
        wr_rd               = 1'b0;
        case (opcode)
            OPC_LUI: begin
                bundle.src_imm = SRC_IMM_U; bundle.src_alu_b = SRC_B_IMM;
                bundle.alu_ctrl = ALU_PASSB; wr_rd = 1'b1;
            end
            OPC_AUIPC: begin
                bundle.src_imm = SRC_IMM_U; bundle.src_alu_a = SRC_A_PC;
                bundle.src_alu_b = SRC_B_IMM; wr_rd = 1'b1;
            end
            OPC_JAL: begin
                bundle.src_imm = SRC_IMM_J; bundle.src_rd = SRC_RD_PC4;
                bundle.src_alu_a = SRC_A_PC; bundle.src_alu_b = SRC_B_IMM; wr_rd = 1'b1;
            end
            OPC_JALR: begin
                bundle.src_imm = SRC_IMM_I; bundle.src_rd = SRC_RD_PC4;
                bundle.src_alu_b = SRC_B_IMM; use_rs1 = 1'b1; wr_rd = 1'b1;
                illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                bundle.src_imm = SRC_IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3[2:1])
                    2'b00:   bundle.alu_ctrl = ALU_SUB;
                    2'b10:   bundle.alu_ctrl = ALU_SLT;
                    2'b11:   bundle.alu_ctrl = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                bundle.src_imm = SRC_IMM_I; bundle.src_alu_b = SRC_B_IMM;
                bundle.src_rd = SRC_RD_MEM; bundle.is_load = 1'b1;
                use_rs1 = 1'b1; wr_rd = 1'b1;
                case (f3)
                    3'b000, 3'b100: bundle.mem_byte_sel = 4'b0001;
                    3'b001, 3'b101: bundle.mem_byte_sel = 4'b0011;
                    3'b010:         bundle.mem_byte_sel = 4'b1111;
                    default:        illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                bundle.src_imm = SRC_IMM_S; bundle.src_alu_b = SRC_B_IMM;
                bundle.mem_wr_en = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'b000:  bundle.mem_byte_sel = 4'b0001;
                    3'b001:  bundle.mem_byte_sel = 4'b0011;
                    3'b010:  bundle.mem_byte_sel = 4'b1111;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                bundle.src_imm = SRC_IMM_I; bundle.src_alu_b = SRC_B_IMM;
                use_rs1 = 1'b1; wr_rd = 1'b1;
                bundle.alu_ctrl = alu_from_f3(f3, (f3 == F3_SR) && (f7 == F7_ALT));
                if (f3 == F3_SLL && f7 != F7_BASE)
                    illegal = 1'b1;
                if (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT)
                    illegal = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1;
                if (f7 == F7_BASE)
                    bundle.alu_ctrl = alu_from_f3(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))
                    bundle.alu_ctrl = alu_from_f3(f3, 1'b1);
`ifdef RISCV_CTRL_MULDIV_EN
                else if (f7 == F7_MDV)
                    bundle.alu_ctrl = {2'b10, f3};
`endif
                else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        bundle.rs1 = use_rs1 ? instr[19:15] : 5'd0;
        bundle.rs2 = use_rs2 ? instr[24:20] : 5'd0;
        bundle.rd  = wr_rd   ? instr[11:7]  : 5'd0;
        bundle.reg_wr_en = wr_rd;
        // Illegal ops must never write state or look like a load to the hazard logic.
        if (illegal) begin
            bundle.reg_wr_en = 1'b0;
            bundle.mem_wr_en = 1'b0;
            bundle.is_load   = 1'b0;
            bundle.rd        = 5'd0;
        end
    end

endmodule

// File: rtl/riscv_ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline: stage registers, load-use/redirect hazards,
// operand forwarding and, with RISCV_CTRL_MULDIV_EN, the multi-cycle divide hold.
module riscv_ctrl_pipe
    import riscv_ctrl_pipe_pkg::*;
#(
    parameter int DIV_LAT = 8,
    parameter int CTRL_W  = CTRL_BUNDLE_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_ctrl_id_valid,
    input  logic [31:0]       i_ctrl_instr,
    output logic              o_ctrl_id_ready,
    input  logic              i_ctrl_hold,
    input  logic              i_ctrl_ex_redirect,
    output logic              o_ctrl_ex_valid,
    output logic              o_ctrl_mem_valid,
    output logic              o_ctrl_wb_valid,
    output logic [CTRL_W-1:0] o_ctrl_ex_bundle,
    output logic [CTRL_W-1:0] o_ctrl_mem_bundle,
    output logic [CTRL_W-1:0] o_ctrl_wb_bundle,
    output logic              o_ctrl_ex_illegal,
    output logic              o_ctrl_stall,
    output logic [1:0]        o_ctrl_fwd_a,
    output logic [1:0]        o_ctrl_fwd_b
);
    if (DIV_LAT < 2 || DIV_LAT > 34) begin : g_bad_div_lat
        $error("riscv_ctrl_pipe: DIV_LAT out of range 2..34");
    end

    ctrl_bundle_t dec_bundle;
    logic         dec_illegal;
    ctrl_bundle_t ex_b, mem_b, wb_b;
    logic         ex_v, mem_v, wb_v, ex_ill;
    logic         load_use, div_busy, ex_take;

    riscv_ctrl_dec u_dec (
        .instr   (i_ctrl_instr),
        .bundle  (dec_bundle),
        .illegal (dec_illegal)
    );

    // Unused operand fields decode to x0, so rd!=0 alone rules out false matches.
    assign load_use = i_ctrl_id_valid && ex_v && ex_b.is_load && ex_b.rd != 5'd0 &&
                      (ex_b.rd == dec_bundle.rs1 || ex_b.rd == dec_bundle.rs2);
    assign ex_take  = i_ctrl_id_valid && !i_ctrl_ex_redirect && !load_use;

`ifdef RISCV_CTRL_MULDIV_EN
    localparam int CNT_W = $clog2(DIV_LAT);
    logic [CNT_W-1:0] div_cnt;
    logic             dec_is_div;

    assign dec_is_div = !dec_illegal && dec_bundle.alu_ctrl[4] && dec_bundle.alu_ctrl[2];
    assign div_busy   = (div_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            div_cnt <= '0;
        else if (!i_ctrl_hold) begin
            if (div_busy)
                div_cnt <= div_cnt - 1'b1;
            else if (ex_take && dec_is_div)
                div_cnt <= CNT_W'(DIV_LAT - 1);
        end
    end
`else
    assign div_busy = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            ex_v   <= 1'b0; ex_b  <= '0; ex_ill <= 1'b0;
            mem_v  <= 1'b0; mem_b <= '0;
            wb_v   <= 1'b0; wb_b  <= '0;
        end else if (!i_ctrl_hold) begin
            wb_v <= mem_v;
            wb_b <= mem_b;
            if (div_busy) begin
                mem_v <= 1'b0;
                mem_b <= '0;
            end else begin
                mem_v  <= ex_v;
                mem_b  <= ex_b;
                ex_v   <= ex_take;
                ex_b   <= ex_take ? dec_bundle : '0;
                ex_ill <= ex_take && dec_illegal;
            end
        end
    end

    // Redirect discards ID even when a load-use match would otherwise stall it.
    assign o_ctrl_id_ready = i_rstn && !i_ctrl_hold && (i_ctrl_ex_redirect || !(load_use || div_busy));
    assign o_ctrl_stall    = i_rstn && (div_busy || (load_use && !i_ctrl_ex_redirect));
    assign o_ctrl_fwd_a    = i_rstn ? fwd_sel(ex_b.rs1, mem_v, mem_b, wb_v, wb_b) : 2'b00;
    assign o_ctrl_fwd_b    = i_rstn ? fwd_sel(ex_b.rs2, mem_v, mem_b, wb_v, wb_b) : 2'b00;

    assign o_ctrl_ex_valid   = ex_v;
    assign o_ctrl_mem_valid  = mem_v;
    assign o_ctrl_wb_valid   = wb_v;
    assign o_ctrl_ex_bundle  = ex_b;
    assign o_ctrl_mem_bundle = mem_b;
    assign o_ctrl_wb_bundle  = wb_b;
    assign o_ctrl_ex_illegal = ex_ill;

endmodule

// File: doc/riscv_ctrl_pipe.md
RISCV_CTRL_PIPE -- requirements
Module: riscv_ctrl_pipe

Interface
REQ-001 SHALL have parameter DIV_LAT, default 8, range 2..34: EX occupancy in cycles of DIV/DIVU/REM/REMU.
REQ-002 SHALL have parameter CTRL_W, default 37: packed control-bundle width, fixed by shared field offsets.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_ctrl_id_valid, input, 1: the ID instruction is valid.
REQ-006 SHALL have port i_ctrl_instr, input, 32: the ID instruction word.
REQ-007 SHALL have port o_ctrl_id_ready, output, 1: the ID instruction is consumed at this edge.
REQ-008 SHALL have port i_ctrl_hold, input, 1: global freeze from memory.
REQ-009 SHALL have port i_ctrl_ex_redirect, input, 1: the EX instruction is a taken branch or jump.
REQ-010 SHALL have ports o_ctrl_ex_valid, o_ctrl_mem_valid and o_ctrl_wb_valid, output, 1 each: the stage holds a real instruction.
REQ-011 SHALL have ports o_ctrl_ex_bundle, o_ctrl_mem_bundle and o_ctrl_wb_bundle, output, CTRL_W each: per-stage control bundle.
REQ-012 SHALL have port o_ctrl_ex_illegal, output, 1: the EX instruction is undecodable.
REQ-013 SHALL have port o_ctrl_stall, output, 1: ID is blocked by a hazard or a divide.
REQ-014 SHALL have ports o_ctrl_fwd_a and o_ctrl_fwd_b, output, 2 each: EX operand source; 00 regfile, 01 MEM, 10 WB.

Function
REQ-015 SHALL define the bundle fields as: src_imm[3], src_rd[2], src_alu_a, src_alu_b, reg_wr_en, mem_wr_en, mem_byte_sel[4], alu_ctrl[5], is_load, rd[5], rs1[5], rs2[5], funct3[3].
REQ-016 SHALL decode the instruction combinationally in ID and register it into EX on the same edge as (i_ctrl_id_valid & o_ctrl_id_ready), giving 1-cycle latency.
REQ-017 SHALL advance EX->MEM->WB one stage per cycle when i_ctrl_hold=0.
REQ-018 SHALL freeze every stage register and the divide counter, and drive o_ctrl_id_ready=0, whenever i_ctrl_hold=1.
REQ-019 SHALL detect load-use: EX valid & is_load & rd!=0 & rd equals the ID rs1 or rs2 (an operand the ID opcode uses) asserts o_ctrl_stall, drives o_ctrl_id_ready=0, and inserts a bubble into EX.
REQ-020 SHALL define a bubble as valid=0 with an all-zero bundle.
REQ-021 SHALL, on i_ctrl_ex_redirect=1, discard the ID instruction: o_ctrl_id_ready=1, and EX receives a bubble; the EX instruction itself proceeds.
REQ-022 SHALL give redirect priority over load-use stall.
REQ-023 SHALL compute o_ctrl_fwd_a from EX rs1 as 01 if MEM valid & reg_wr_en & rd!=0 & rd==rs1, else 10 under the same condition on WB, else 00.
REQ-024 SHALL compute o_ctrl_fwd_b in the same way from EX rs2; MEM wins over WB.
REQ-025 SHALL, for an illegal opcode or funct, set o_ctrl_ex_illegal=1 with reg_wr_en=0 and mem_wr_en=0, and keep valid=1.
REQ-026 SHALL keep o_ctrl_ex_illegal registered alongside EX and 0 whenever EX holds a bubble.
REQ-027 SHALL set mem_byte_sel to 0001 for B/BU, 0011 for H/HU, and 1111 otherwise.
REQ-028 SHALL use SUB for BEQ/BNE, SLT for BLT/BGE, and SLTU for BLTU/BGEU.

Reset
REQ-029 SHALL, while i_rstn=0 at a clock edge, clear all valids, bundles, o_ctrl_ex_illegal and the divide counter.
REQ-030 SHALL hold o_ctrl_stall=0, o_ctrl_fwd_a=00, o_ctrl_fwd_b=00 and o_ctrl_id_ready=0 during reset.
REQ-031 SHALL, on reset mid-divide, abort the divide; the next cycle is idle.

Configuration
REQ-032 SHALL, with macro RISCV_CTRL_MULDIV_EN defined, decode OPCODE_R_OP with funct7=0000001 to alu_ctrl MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
REQ-033 SHALL, with RISCV_CTRL_MULDIV_EN defined, complete MUL variants in 1 EX cycle.
REQ-034 SHALL, with RISCV_CTRL_MULDIV_EN defined, load DIV_LAT-1 into the counter on DIV/REM entry to EX, then hold EX, drive MEM bubbles, assert o_ctrl_stall, and keep o_ctrl_id_ready=0 until the counter reaches 0, decrementing per non-hold cycle.
REQ-035 SHALL, without RISCV_CTRL_MULDIV_EN, treat funct7=0000001 as illegal and generate no counter logic.

Structure
REQ-036 SHALL place opcode, funct3, SRC_*, 5-bit ALU_CTRL codes (incl. MUL/DIV) and bundle field offsets/CTRL_W in shared riscv_configs.v.
REQ-037 SHALL implement the combinational decoder as sub-module riscv_ctrl_dec (instr -> bundle, illegal); riscv_ctrl_pipe holds stage registers, hazard, forwarding and divide logic.

Verification
REQ-038 SHALL test load-use: 0x0000A283 (lw x5,0(x1)), then 0x00228333 (add x6,x5,x2) -> stall=1 for 1 cycle, EX bubble, then add in EX with fwd_a=10, fwd_b=00.
REQ-039 SHALL test MEM forwarding: 0x00500093 (addi x1,x0,5), then 0x00108133 (add x2,x1,x1) -> add in EX with fwd_a=01, fwd_b=01, no stall.
REQ-040 SHALL test redirect: i_ctrl_ex_redirect=1 with 0x00108133 valid in ID -> id_ready=1, next cycle ex_valid=0; redirect together with a load-use match -> bubble only, stall ignored.
REQ-041 SHALL test illegal: 0xFFFFFFFF -> next cycle ex_valid=1, ex_illegal=1, reg_wr_en=0, mem_wr_en=0.
REQ-042 SHALL test divide: with RISCV_CTRL_MULDIV_EN and DIV_LAT=8, 0x0262C3B3 (div x7,x5,x6) -> EX occupied 8 cycles, stall=1 for 7, mem_valid=0 for 7; hold=1 for 3 mid-divide -> 11 cycles; without the macro -> ex_illegal=1.
REQ-043 SHALL test reset: i_rstn=0 mid-divide and with all stages full -> next edge all valids 0, bundles 0, stall 0.
